// File: rtl/imem_uart_dump.sv
// Walks a DEPTH x 16 memory read port and sends every word over an 8N1 UART line,
// high byte first, so the dump can be fed back to the instruction loader unchanged.
module imem_uart_dump #(
    parameter int CLKS_PER_BAUD = 868,
    parameter int DEPTH         = 32,
    parameter int ADDR_W        = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              UART_RXD_OUT,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W     = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [15:0]       word_q, word_d;
    logic              byte_sel_q, byte_sel_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_byte;
    logic              baud_last;

    always_comb begin
        cur_byte  = byte_sel_q ? word_q[7:0] : word_q[15:8];
        baud_last = (cnt_q == CNT_LAST);
    end

    // line_d is the level the line takes in the state being entered, so the
    // pin is a plain flop with no decode glitches.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        word_addr_d = word_addr_q;
        word_d      = word_q;
        byte_sel_d  = byte_sel_q;
        line_d      = line_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (start) begin
                    word_addr_d = '0;
                    busy_d      = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                word_d     = rd_data;
                byte_sel_d = 1'b0;
                cnt_d      = '0;
                line_d     = 1'b0;
                state_d    = START_BIT;
            end
            START_BIT: begin
                if (baud_last) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    line_d    = cur_byte[0];
                    state_d   = DATA_BITS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        line_d    = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                if (baud_last) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        line_d     = 1'b0;
                        state_d    = START_BIT;
                    end else begin
                        line_d  = 1'b1;
                        done_d  = (word_addr_q == ADDR_LAST);
                        state_d = NEXT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                line_d = 1'b1;
                if (word_addr_q == ADDR_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    word_addr_d = word_addr_q + ADDR_W'(1);
                    state_d     = FETCH;
                end
            end
            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            word_addr_q <= '0;
            word_q      <= 16'h0000;
            byte_sel_q  <= 1'b0;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            word_addr_q <= word_addr_d;
            word_q      <= word_d;
            byte_sel_q  <= byte_sel_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The address only moves in NEXT, so it is stable for a whole word.
    assign rd_addr      = word_addr_q;
    assign UART_RXD_OUT = line_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
